fetch_ifid: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, including the IF/ID pipeline register.
- Holds the PC and presents it to the external instruction memory.
- Latches the fetched word into instr_D. instr_D feeds the D-stage control decoder.
- Consumes the decoder's branch/jump flags plus forwarded rs/rt to compute next PC. Architectural delay slot is always executed; no flush.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/fetch_ifid_if.sv | 41 ++++
 rtl/fetch_ifid_npc_calc.sv | 62 ++++++
 rtl/fetch_ifid.sv | 71 +++++++
 tb/tb_fetch_ifid.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the fetch stage and the D-stage decoder.
// Holds the reset vector, the canonical nop, the encoding constants and target helpers.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes (instr[5:0]).
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    // REGIMM rt selectors (instr[20:16]).
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Control-transfer flags as produced by the decoder, MSB first.
    typedef struct packed {
        logic beq;
        logic bne;
        logic bltz;
        logic blez;
        logic bgez;
        logic bgtz;
        logic bgezal;
        logic bltzal;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
    } ctl_flags_t;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_REG    = 2'd3
    } npc_sel_e;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_d,
                                                  input logic [31:0] instr_d);
        logic [31:0] offset;
        offset = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
        return pc_d + 32'd4 + offset;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_d,
                                                input logic [31:0] instr_d);
        return {pc_d[31:28], instr_d[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// Bundle between the fetch stage and its neighbours: instruction memory,
// D-stage decoder flags, forwarded operands and the IF/ID register outputs.
interface fetch_ifid_if;
    import mips_pkg::*;

    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic [31:0] rs_D;
    logic [31:0] rt_D;
    logic        beq;
    logic        bne;
    logic        bltz;
    logic        blez;
    logic        bgez;
    logic        bgtz;
    logic        bgezal_D;
    logic        bltzal_D;
    logic        j;
    logic        jal_D;
    logic        jr;
    logic        jalr_D;
    logic        redirect_D;

    modport master (
        output pc_F, instr_D, pc_D, pc8_D, redirect_D,
        input  instr_F, rs_D, rt_D,
        input  beq, bne, bltz, blez, bgez, bgtz, bgezal_D, bltzal_D,
        input  j, jal_D, jr, jalr_D
    );

    modport slave (
        input  pc_F, instr_D, pc_D, pc8_D, redirect_D,
        output instr_F, rs_D, rt_D,
        output beq, bne, bltz, blez, bgez, bgtz, bgezal_D, bltzal_D,
        output j, jal_D, jr, jalr_D
    );

endinterface

// File: rtl/fetch_ifid_npc_calc.sv
// Next-PC selection for the fetch stage: resolves the D-stage branch/jump
// against forwarded operands and picks register, jump, branch or sequential PC.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_F,
    input  logic [31:0] pc_D,
    input  logic [31:0] instr_D,
    input  logic [31:0] rs_D,
    input  logic [31:0] rt_D,
    input  ctl_flags_t  flags,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic     rs_neg_s;
    logic     rs_zero_s;
    logic     rs_eq_rt_s;
    logic     taken_s;
    logic     jump_any_s;
    npc_sel_e sel_s;

    // Branch condition evaluation on signed operands.
    always_comb begin
        rs_neg_s   = ($signed(rs_D) < 32'sd0);
        rs_zero_s  = (rs_D == 32'h0000_0000);
        rs_eq_rt_s = (rs_D == rt_D);
        taken_s    = (flags.beq  &  rs_eq_rt_s)
                   | (flags.bne  & ~rs_eq_rt_s)
                   | ((flags.bltz | flags.bltzal) &  rs_neg_s)
                   | ((flags.bgez | flags.bgezal) & ~rs_neg_s)
                   | (flags.blez & (rs_neg_s | rs_zero_s))
                   | (flags.bgtz & ~rs_neg_s & ~rs_zero_s);
        jump_any_s = flags.j | flags.jal | flags.jr | flags.jalr;
    end

    // Priority select: register jumps outrank direct jumps, which outrank branches.
    always_comb begin
        if (flags.jr | flags.jalr) begin
            sel_s = NPC_REG;
        end else if (flags.j | flags.jal) begin
            sel_s = NPC_JUMP;
        end else if (taken_s) begin
            sel_s = NPC_BRANCH;
        end else begin
            sel_s = NPC_SEQ;
        end
    end

    // Next-PC mux and redirect indication.
    always_comb begin
        case (sel_s)
            NPC_REG:    next_pc = rs_D;
            NPC_JUMP:   next_pc = jump_target(pc_D, instr_D);
            NPC_BRANCH: next_pc = branch_target(pc_D, instr_D);
            NPC_SEQ:    next_pc = pc_F + 32'd4;
            default:    next_pc = pc_F + 32'd4;
        endcase
        redirect = jump_any_s | taken_s;
    end

endmodule

// File: rtl/fetch_ifid.sv
// IF stage with IF/ID pipeline register: PC, fetched word and its address.
// The delay slot is always executed; stall freezes all three registers.
module fetch_ifid
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    fetch_ifid_if.master  bus
);

    logic [31:0] pc_f_r;
    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] next_pc_s;
    logic        redirect_s;
    ctl_flags_t  flags_s;

    // Gather decoder flags into one record for the next-PC logic.
    always_comb begin
        flags_s.beq    = bus.beq;
        flags_s.bne    = bus.bne;
        flags_s.bltz   = bus.bltz;
        flags_s.blez   = bus.blez;
        flags_s.bgez   = bus.bgez;
        flags_s.bgtz   = bus.bgtz;
        flags_s.bgezal = bus.bgezal_D;
        flags_s.bltzal = bus.bltzal_D;
        flags_s.j      = bus.j;
        flags_s.jal    = bus.jal_D;
        flags_s.jr     = bus.jr;
        flags_s.jalr   = bus.jalr_D;
    end

    npc_calc u_npc_calc (
        .pc_F     (pc_f_r),
        .pc_D     (pc_d_r),
        .instr_D  (instr_d_r),
        .rs_D     (bus.rs_D),
        .rt_D     (bus.rt_D),
        .flags    (flags_s),
        .next_pc  (next_pc_s),
        .redirect (redirect_s)
    );

    // PC and IF/ID register; reset overrides stall, stall holds everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_f_r    <= RESET_PC;
            instr_d_r <= NOP_INSTR;
            pc_d_r    <= 32'h0000_0000;
        end else if (!stall) begin
            pc_f_r    <= next_pc_s;
            instr_d_r <= bus.instr_F;
            pc_d_r    <= pc_f_r;
        end else begin
            pc_f_r    <= pc_f_r;
            instr_d_r <= instr_d_r;
            pc_d_r    <= pc_d_r;
        end
    end

    assign bus.pc_F       = pc_f_r;
    assign bus.instr_D    = instr_d_r;
    assign bus.pc_D       = pc_d_r;
    assign bus.pc8_D      = pc_d_r + 32'd8;
    assign bus.redirect_D = redirect_s;

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: table of control-transfer vectors plus
// hand sequences for reset, stall and delay-slot behaviour.
module tb_fetch_ifid;
    import mips_pkg::*;

    localparam logic [11:0] F_NONE   = 12'b0000_0000_0000;
    localparam logic [11:0] F_BEQ    = 12'b1000_0000_0000;
    localparam logic [11:0] F_BNE    = 12'b0100_0000_0000;
    localparam logic [11:0] F_BLTZ   = 12'b0010_0000_0000;
    localparam logic [11:0] F_BLEZ   = 12'b0001_0000_0000;
    localparam logic [11:0] F_BGEZ   = 12'b0000_1000_0000;
    localparam logic [11:0] F_BGTZ   = 12'b0000_0100_0000;
    localparam logic [11:0] F_BGEZAL = 12'b0000_0010_0000;
    localparam logic [11:0] F_BLTZAL = 12'b0000_0001_0000;
    localparam logic [11:0] F_J      = 12'b0000_0000_1000;
    localparam logic [11:0] F_JAL    = 12'b0000_0000_0100;
    localparam logic [11:0] F_JR     = 12'b0000_0000_0010;
    localparam logic [11:0] F_JALR   = 12'b0000_0000_0001;
    localparam int          NVEC     = 20;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [11:0] fl;
        logic [31:0] exp_npc;
        logic        exp_redir;
    } vec_t;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr_d;
        logic [31:0] pc_d;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        stall;
    int          checks;
    int          errors;
    logic [31:0] cur_pc_f;
    logic [31:0] cur_instr_d;
    logic [31:0] cur_pc_d;
    exp_t        sb[$];
    vec_t        vecs[NVEC];

    fetch_ifid_if bus_if ();

    fetch_ifid #(.RESET_PC(32'h0000_3000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [11:0] f);
        ctl_flags_t c;
        c = f;
        bus_if.beq      = c.beq;
        bus_if.bne      = c.bne;
        bus_if.bltz     = c.bltz;
        bus_if.blez     = c.blez;
        bus_if.bgez     = c.bgez;
        bus_if.bgtz     = c.bgtz;
        bus_if.bgezal_D = c.bgezal;
        bus_if.bltzal_D = c.bltzal;
        bus_if.j        = c.j;
        bus_if.jal_D    = c.jal;
        bus_if.jr       = c.jr;
        bus_if.jalr_D   = c.jalr;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " pc_F"},    bus_if.pc_F,    e.pc_f);
            check({tag, " instr_D"}, bus_if.instr_D, e.instr_d);
            check({tag, " pc_D"},    bus_if.pc_D,    e.pc_d);
            check({tag, " pc8_D"},   bus_if.pc8_D,   e.pc_d + 32'd8);
        end
    endtask

    // Unstalled edge: the word on instr_F and the current PC move into D.
    task automatic drive_edge(input logic [31:0] exp_npc, input string tag);
        exp_t e;
        e.pc_f    = exp_npc;
        e.instr_d = bus_if.instr_F;
        e.pc_d    = cur_pc_f;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cur_pc_f    = e.pc_f;
        cur_instr_d = e.instr_d;
        cur_pc_d    = e.pc_d;
        compare_out(tag);
    endtask

    task automatic hold_edge(input string tag);
        exp_t e;
        e.pc_f    = cur_pc_f;
        e.instr_d = cur_instr_d;
        e.pc_d    = cur_pc_d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Places instr at pc_D=pc via a jr, then leaves it in D with pc_F=pc+4.
    task automatic load_d(input logic [31:0] pc, input logic [31:0] instr, input string tag);
        set_flags(F_JR);
        bus_if.rs_D    = pc;
        bus_if.instr_F = NOP_INSTR;
        drive_edge(pc, {tag, " setup_jr"});
        set_flags(F_NONE);
        bus_if.instr_F = instr;
        drive_edge(pc + 32'd4, {tag, " setup_fetch"});
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [11:0] fl,
                                input logic [31:0] npc, input logic redir);
        vec_t v;
        v.name = n; v.pc = pc; v.instr = instr; v.rs = rs; v.rt = rt;
        v.fl = fl; v.exp_npc = npc; v.exp_redir = redir;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = mk("beq_taken",   32'h0000_3004, 32'h1000_0003, 32'd5, 32'd5, F_BEQ, 32'h0000_3014, 1'b1);
        vecs[1]  = mk("beq_not",     32'h0000_3004, 32'h1000_0003, 32'd5, 32'd6, F_BEQ, 32'h0000_300C, 1'b0);
        vecs[2]  = mk("bne_taken",   32'h0000_3100, 32'h1400_0010, 32'd5, 32'd6, F_BNE, 32'h0000_3144, 1'b1);
        vecs[3]  = mk("bltz_min",    32'h0000_3200, 32'h0400_0002, 32'h8000_0000, 32'd0, F_BLTZ, 32'h0000_320C, 1'b1);
        vecs[4]  = mk("bgtz_zero",   32'h0000_3200, 32'h1C00_0002, 32'd0, 32'd0, F_BGTZ, 32'h0000_3208, 1'b0);
        vecs[5]  = mk("blez_zero",   32'h0000_3200, 32'h1800_0002, 32'd0, 32'd0, F_BLEZ, 32'h0000_320C, 1'b1);
        vecs[6]  = mk("bgez_negimm", 32'h0000_3010, 32'h0401_FFFE, 32'h7FFF_FFFF, 32'd0, F_BGEZ, 32'h0000_300C, 1'b1);
        vecs[7]  = mk("bgezal_neg",  32'h0000_3300, 32'h0411_0004, 32'hFFFF_FFFF, 32'd0, F_BGEZAL, 32'h0000_3308, 1'b0);
        vecs[8]  = mk("bltzal_neg",  32'h0000_3300, 32'h0410_0004, 32'hFFFF_FFFF, 32'd0, F_BLTZAL, 32'h0000_3314, 1'b1);
        vecs[9]  = mk("jal",         32'h0000_3020, 32'h0C00_0C10, 32'd0, 32'd0, F_JAL, 32'h0000_3040, 1'b1);
        vecs[10] = mk("jr",          32'h0000_3400, 32'h0000_0008, 32'h0000_3100, 32'd0, F_JR, 32'h0000_3100, 1'b1);
        vecs[11] = mk("jr_over_j",   32'h0000_3400, 32'h0800_0100, 32'h0000_3500, 32'd0, F_JR | F_J, 32'h0000_3500, 1'b1);
        vecs[12] = mk("jalr_unalig", 32'h0000_3400, 32'h0000_0009, 32'h0000_3003, 32'd0, F_JALR, 32'h0000_3003, 1'b1);
        vecs[13] = mk("j_over_beq",  32'h0000_3600, 32'h0800_0040, 32'd7, 32'd7, F_BEQ | F_J, 32'h0000_0100, 1'b1);
        vecs[14] = mk("bgtz_pos",    32'h0000_3200, 32'h1C00_0003, 32'd1, 32'd0, F_BGTZ, 32'h0000_3210, 1'b1);
        vecs[15] = mk("j_upper",     32'hA000_0000, 32'h0BFF_FFFF, 32'd0, 32'd0, F_J, 32'hAFFF_FFFC, 1'b1);
        vecs[16] = mk("pc_wrap",     32'hFFFF_FFF8, 32'h0000_0000, 32'd0, 32'd0, F_NONE, 32'h0000_0000, 1'b0);
        vecs[17] = mk("blez_pos",    32'h0000_3200, 32'h1800_0002, 32'd1, 32'd0, F_BLEZ, 32'h0000_3208, 1'b0);
        vecs[18] = mk("bne_equal",   32'h0000_3100, 32'h1400_0010, 32'd9, 32'd9, F_BNE, 32'h0000_3108, 1'b0);
        vecs[19] = mk("bltz_zero",   32'h0000_3200, 32'h0400_0002, 32'd0, 32'd0, F_BLTZ, 32'h0000_3208, 1'b0);

        // Reset then sequential fetch.
        reset_n        = 1'b0;
        stall          = 1'b0;
        bus_if.instr_F = NOP_INSTR;
        bus_if.rs_D    = 32'h0;
        bus_if.rt_D    = 32'h0;
        set_flags(F_NONE);
        repeat (2) @(posedge clk);
        #1;
        check("reset pc_F",    bus_if.pc_F,    32'h0000_3000);
        check("reset instr_D", bus_if.instr_D, 32'h0000_0000);
        check("reset pc_D",    bus_if.pc_D,    32'h0000_0000);
        check("reset redirect_D", {31'd0, bus_if.redirect_D}, 32'd0);
        cur_pc_f    = 32'h0000_3000;
        cur_instr_d = 32'h0000_0000;
        cur_pc_d    = 32'h0000_0000;
        reset_n        = 1'b1;
        bus_if.instr_F = 32'h3C01_1234;
        drive_edge(32'h0000_3004, "first_fetch");
        check("first_fetch pc8_D abs", bus_if.pc8_D, 32'h0000_3008);

        // Table of control-transfer cases, each with its delay slot.
        for (int i = 0; i < NVEC; i++) begin
            load_d(vecs[i].pc, vecs[i].instr, vecs[i].name);
            bus_if.instr_F = 32'h2400_0000 | 32'(i);
            bus_if.rs_D    = vecs[i].rs;
            bus_if.rt_D    = vecs[i].rt;
            set_flags(vecs[i].fl);
            #1;
            check({vecs[i].name, " redirect_D"}, {31'd0, bus_if.redirect_D}, {31'd0, vecs[i].exp_redir});
            drive_edge(vecs[i].exp_npc, vecs[i].name);
            set_flags(F_NONE);
        end

        // Stalled branch re-evaluates with the operands present at release.
        load_d(32'h0000_3004, 32'h1000_0003, "stall");
        set_flags(F_BEQ);
        stall       = 1'b1;
        bus_if.rs_D = 32'd5;
        bus_if.rt_D = 32'd6;
        for (int k = 0; k < 3; k++) begin
            bus_if.instr_F = 32'h2400_00A0 + 32'(k);
            hold_edge("stall_hold");
        end
        stall          = 1'b0;
        bus_if.rt_D    = 32'd5;
        bus_if.instr_F = 32'h2400_00AA;
        #1;
        check("stall_release redirect_D", {31'd0, bus_if.redirect_D}, 32'd1);
        drive_edge(32'h0000_3014, "stall_release");
        set_flags(F_NONE);

        // Reset in the middle of a stalled jump.
        load_d(32'h0000_3020, 32'h0C00_0C10, "midreset");
        set_flags(F_JAL);
        stall          = 1'b1;
        reset_n        = 1'b0;
        bus_if.instr_F = 32'h2400_00BB;
        @(posedge clk);
        #1;
        set_flags(F_NONE);
        #1;
        check("midreset pc_F",       bus_if.pc_F,    32'h0000_3000);
        check("midreset instr_D",    bus_if.instr_D, 32'h0000_0000);
        check("midreset pc_D",       bus_if.pc_D,    32'h0000_0000);
        check("midreset pc8_D",      bus_if.pc8_D,   32'h0000_0008);
        check("midreset redirect_D", {31'd0, bus_if.redirect_D}, 32'd0);
        cur_pc_f    = 32'h0000_3000;
        cur_instr_d = 32'h0000_0000;
        cur_pc_d    = 32'h0000_0000;
        reset_n        = 1'b1;
        stall          = 1'b0;
        bus_if.instr_F = 32'h3C01_5678;
        drive_edge(32'h0000_3004, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
